// File: rtl/fuzz_round_controller.sv
// Fuzzing-round sequencer: boot reset hold, run with stall/watchdog interrupt, loader handshake per pass.
// Outputs are decoded from registered state; the loader handshake is a level request with a one-cycle ack.
module fuzz_round_controller #(
  parameter int COV_W        = 30,
  parameter int STALL_CYCLES = 1000,
  parameter int WDOG_CYCLES  = 10000,
  parameter int RESET_HOLD   = 8,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [63:0]      tohost,
  input  logic [COV_W-1:0] cov,
  input  logic             fuzz_en,
  output logic             load_req,
  input  logic             load_ack,
  output logic             core_reset,
  output logic             interrupt,
  output logic             done,
  output logic [CNT_W-1:0] round_cnt
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_RUN,
    S_REQ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] wdog_cnt;
  logic [COV_W-1:0] pre_cov;
  logic             pass;
  logic             hold_last;
  logic             unused_tohost;

  assign pass          = tohost[0];
  assign unused_tohost = ^tohost[63:1];
  assign hold_last     = (hold_cnt == CNT_W'(RESET_HOLD - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT, S_HOLD: if (hold_last) state_nxt = S_RUN;
      S_RUN:          if (pass) state_nxt = fuzz_en ? S_REQ : S_DONE;
      S_REQ:          if (load_ack) state_nxt = S_HOLD;
      S_DONE:         state_nxt = S_DONE;
      default:        state_nxt = S_BOOT;
    endcase
  end

  // A pass takes priority over coverage/watchdog bookkeeping in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt  <= '0;
      stall_cnt <= '0;
      wdog_cnt  <= '0;
      pre_cov   <= '0;
      round_cnt <= '0;
    end else begin
      case (state)
        S_BOOT, S_HOLD: begin
          if (hold_last) begin
            hold_cnt  <= '0;
            stall_cnt <= '0;
            wdog_cnt  <= '0;
            pre_cov   <= '0;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (pass) begin
            round_cnt <= round_cnt + CNT_W'(1);
          end else begin
            if (cov != pre_cov) begin
              pre_cov   <= cov;
              stall_cnt <= '0;
            end else if (~&stall_cnt) begin
              stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (~&wdog_cnt) wdog_cnt <= wdog_cnt + CNT_W'(1);
          end
        end
        S_REQ: hold_cnt <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    core_reset = (state != S_RUN);
    load_req   = (state == S_REQ);
    done       = (state == S_DONE);
    interrupt  = (state == S_RUN) &&
                 ((stall_cnt >= CNT_W'(STALL_CYCLES)) || (wdog_cnt >= CNT_W'(WDOG_CYCLES)));
  end

endmodule

// File: tb/tb_fuzz_round_controller.sv
// Directed bench for fuzz_round_controller: stimulus queues cycle-stamped expected outputs,
// a negedge monitor pops and compares them.
module tb_fuzz_round_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] tohost;
  logic [7:0]  cov;
  logic        fuzz_en;
  logic        load_req;
  logic        load_ack;
  logic        core_reset;
  logic        interrupt;
  logic        done;
  logic [31:0] round_cnt;

  fuzz_round_controller #(
    .COV_W(8), .STALL_CYCLES(4), .WDOG_CYCLES(10), .RESET_HOLD(3), .CNT_W(32)
  ) dut (
    .clock(clock), .reset(reset), .tohost(tohost), .cov(cov), .fuzz_en(fuzz_en),
    .load_req(load_req), .load_ack(load_ack), .core_reset(core_reset),
    .interrupt(interrupt), .done(done), .round_cnt(round_cnt)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    int          at;
    logic        cr;
    logic        lr;
    logic        irq;
    logic        dn;
    logic [31:0] rc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic push_exp(input int d, input string nm, input logic cr, input logic lr,
                          input logic irq, input logic dn, input logic [31:0] rc);
    exp_t e;
    e.at = cyc + d; e.cr = cr; e.lr = lr; e.irq = irq; e.dn = dn; e.rc = rc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  exp_t        m_e;
  string       m_nm;
  logic [35:0] m_act;
  logic [35:0] m_req;

  // Outputs are {core_reset, load_req, interrupt, done, round_cnt}.
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      n_checks++;
      m_act = {core_reset, load_req, interrupt, done, round_cnt};
      m_req = {m_e.cr, m_e.lr, m_e.irq, m_e.dn, m_e.rc};
      if (m_e.at != cyc) begin
        n_fail++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", m_nm, cyc, m_e.at);
      end else if (m_act !== m_req) begin
        n_fail++;
        $display("FAIL %s: cycle %0d got cr/lr/irq/dn/rc=%b%b%b%b/%0d, required %b%b%b%b/%0d",
                 m_nm, cyc, m_act[35], m_act[34], m_act[33], m_act[32], m_act[31:0],
                 m_req[35], m_req[34], m_req[33], m_req[32], m_req[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; tohost = '0; cov = '0; fuzz_en = 1'b0; load_ack = 1'b0;
    step(2);
    push_exp(0, "reset_state", 1, 0, 0, 0, 0);

    // Boot hold, then stall with constant cov.
    reset = 1'b0; cov = 8'd5;
    push_exp(1, "boot_1",      1, 0, 0, 0, 0);
    push_exp(2, "boot_2",      1, 0, 0, 0, 0);
    push_exp(3, "run_entry",   0, 0, 0, 0, 0);
    push_exp(7, "stall_below", 0, 0, 0, 0, 0);
    push_exp(8, "stall_irq",   0, 0, 1, 0, 0);
    step(8);
    cov = 8'd6;
    push_exp(1, "stall_clear", 0, 0, 0, 0, 0);
    push_exp(4, "wdog_below",  0, 0, 0, 0, 0);
    push_exp(5, "wdog_irq",    0, 0, 1, 0, 0);
    push_exp(8, "wdog_hold",   0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1);
      cov = cov ^ 8'h01;
    end
    step(1);

    // Pass with fuzz_en while the watchdog interrupt is high.
    tohost = 64'd1; fuzz_en = 1'b1;
    push_exp(1, "pass_req", 1, 1, 0, 0, 1);
    step(1);
    tohost = '0; fuzz_en = 1'b0;
    push_exp(6, "req_wait", 1, 1, 0, 0, 1);
    step(6);
    load_ack = 1'b1;
    push_exp(1, "ack_drop",      1, 0, 0, 0, 1);
    push_exp(3, "hold_end",      1, 0, 0, 0, 1);
    push_exp(4, "release",       0, 0, 0, 0, 1);
    push_exp(8, "cleared_below", 0, 0, 0, 0, 1);
    push_exp(9, "stall_again",   0, 0, 1, 0, 1);
    step(1);
    load_ack = 1'b0;
    step(8);

    // Terminal pass colliding with the stall threshold; later ack and pass ignored.
    tohost = 64'd1; fuzz_en = 1'b0;
    push_exp(1, "collide_done", 1, 0, 0, 1, 2);
    step(1);
    tohost = '0;
    step(1);
    load_ack = 1'b1; tohost = 64'd1;
    push_exp(2, "done_hold", 1, 0, 0, 1, 2);
    step(1);
    load_ack = 1'b0; tohost = '0;
    step(1);

    // Reset from DONE, new round, then reset while load_req is up.
    reset = 1'b1;
    push_exp(1, "rst_from_done", 1, 0, 0, 0, 0);
    step(1);
    reset = 1'b0;
    push_exp(3, "reboot_run", 0, 0, 0, 0, 0);
    step(3);
    tohost = 64'd1; fuzz_en = 1'b1;
    push_exp(1, "pass_req2", 1, 1, 0, 0, 1);
    step(1);
    tohost = '0; reset = 1'b1;
    push_exp(1, "rst_mid_req", 1, 0, 0, 0, 0);
    step(1);
    reset = 1'b0;
    push_exp(2, "boot_again", 1, 0, 0, 0, 0);
    push_exp(3, "run_again",  0, 0, 0, 0, 0);
    step(5);

    while (name_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never sampled, required cycle %0d", name_q.pop_front(), exp_q.pop_front().at);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzz_round_controller.md
# fuzz_round_controller

Synthesizable sequencer for RTL fuzzing rounds. It watches the DUT's `tohost` pass flag and its coverage sum, and raises the stall/watchdog interrupt that is forced onto the core's MSIP. On each pass it holds the core in reset, handshakes with the testcase loader for the next image, then releases reset. It sits beside the test harness and replaces bench-side `fuzz_manager` and `coverage_monitor` sequencing with cycle-exact hardware.

## Interface
- `COV_W`, default 30: coverage sum width.
- `STALL_CYCLES`, default 1000: cycles without a coverage change before the interrupt fires.
- `WDOG_CYCLES`, default 10000: cycles in a round without a pass before the interrupt fires.
- `RESET_HOLD`, default 8: cycles `core_reset` is held after boot and after each load (≥1).
- `CNT_W`, default 32: width of the stall/watchdog counters and `round_cnt`.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `tohost`  in  64  DUT tohost word; bit 0 = pass.
- `cov`  in  COV_W  DUT coverage sum.
- `fuzz_en`  in  1  1 = start a new round after each pass; 0 = stop at the first pass.
- `load_req`  out  1  request to the loader for the next testcase image.
- `load_ack`  in  1  loader finished writing memory; one-cycle pulse.
- `core_reset`  out  1  reset to the DUT core/SoC.
- `interrupt`  out  1  stall/watchdog interrupt to the core's MSIP.
- `done`  out  1  terminal pass reached (only when `fuzz_en=0`).
- `round_cnt`  out  CNT_W  number of completed passes.

## Operation
- Reset values: state=BOOT, `core_reset`=1, `load_req`=0, `interrupt`=0, `done`=0, `round_cnt`=0. All internal counters and `pre_cov` are 0.
- States and transitions:
  - **BOOT**: `core_reset`=1. `hold_cnt` increments each cycle. When it reaches RESET_HOLD-1, go to RUN.
  - **RUN**: `core_reset`=0.
    - If `tohost[0]`=1: `round_cnt`+1 (wraps at 2^CNT_W). Go to REQ if `fuzz_en`=1, otherwise DONE.
    - Else, coverage tracking: if `cov`≠`pre_cov`, then `pre_cov`←`cov` and `stall_cnt`←0; otherwise `stall_cnt`+1.
    - `wdog_cnt`+1 each RUN cycle without a pass.
    - Both counters saturate at all-ones.
  - **REQ**: `core_reset`=1 and `load_req`=1. Wait for `load_ack`. On ack, `load_req` drops next cycle and state goes to HOLD with `hold_cnt`←0.
  - **HOLD**: `core_reset`=1. Identical to BOOT, then RUN.
  - **DONE**: `core_reset`=1 and `done`=1. Terminal until `reset`.
- Entering RUN from BOOT or HOLD clears `stall_cnt`, `wdog_cnt` and `pre_cov`.
- `interrupt` = (state==RUN) && (`stall_cnt`≥STALL_CYCLES || `wdog_cnt`≥WDOG_CYCLES). It is decoded from registers and is never high outside RUN.
- Simultaneous events:
  - Pass and threshold in the same cycle: the pass wins. Counters are not updated and `interrupt` drops next cycle.
  - `load_ack` outside REQ is ignored.
  - A pass seen in a non-RUN state is ignored.
- `fuzz_en` is sampled only in the pass cycle.
- `reset` mid-round, in any state, returns the block to the reset values on the next edge. An outstanding `load_req` is withdrawn without an ack.

## Timing
- Boot: `core_reset` is high for exactly RESET_HOLD cycles after `reset` deasserts.
- Pass to reset: `tohost[0]` sampled at edge N gives `core_reset`=1 and `load_req`=1 from edge N+1.
- Ack to release: `load_ack` at edge M gives `load_req`=0 at M+1. `core_reset` falls at M+1+RESET_HOLD.
- Stall: with `cov` constant after the first RUN cycle, `interrupt` rises STALL_CYCLES+1 cycles after RUN entry. It falls one cycle after the `cov` change is sampled.
- Watchdog: `interrupt` rises WDOG_CYCLES cycles after RUN entry when there is no pass. It can only be cleared by a pass or by `reset`.
- Minimum round overhead is 1 (REQ) + ack latency + RESET_HOLD cycles.

## Test plan
Parameters for all scenarios: STALL_CYCLES=4, WDOG_CYCLES=10, RESET_HOLD=3, COV_W=8.
- **Boot:** deassert `reset` → `core_reset` high for 3 cycles then 0. Outputs `load_req`, `interrupt`, `done` and `round_cnt` are all 0.
- **Stall:** RUN with `cov`=5 constant → `interrupt`=1 at RUN cycle 5. Set `cov`=6 → `interrupt`=0 one cycle later.
- **Watchdog:** toggle `cov` every cycle, no pass → `interrupt`=1 at RUN cycle 10 and stays high.
- **Fuzz round:** `fuzz_en`=1, pulse `tohost`=1 → next cycle `core_reset`=1, `load_req`=1, `round_cnt`=1. `load_ack` after 7 cycles → `load_req`=0 next cycle, `core_reset`=0 three cycles later, counters cleared.
- **Terminal and collision:** `fuzz_en`=0, `tohost`=1 in the same cycle that `stall_cnt` reaches 4 → DONE, `done`=1, `interrupt`=0, `core_reset`=1, `round_cnt`=1. A later `load_ack` is ignored.
- **Reset mid-REQ:** assert `reset` while `load_req`=1 → next cycle `load_req`=0, `round_cnt`=0, state BOOT.
